// File: rtl/ram_ctrl_pkg.sv
// Shared types for the data-RAM access controller: FSM encoding and strobe width.
package ram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-strobe merge for the read-modify-write store path.
module byte_merge
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   old_data_i,
  input  logic [DATA_WIDTH-1:0]   new_data_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_byte
      assign merged_o[gi*8 +: 8] = be_i[gi] ? new_data_i[gi*8 +: 8] : old_data_i[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/ram_access_ctrl.sv
// Load/store initiator for the synchronous data RAM; absorbs the 1-cycle read latency.
// Optional MEM_BYTE_STROBE_EN builds the byte-strobe read-modify-write store path.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic                    ram_mwrite,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  state_e                  state_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic [ADDR_WIDTH-1:0]   ram_raddr_q;
  logic [ADDR_WIDTH-1:0]   ram_waddr_q;
  logic                    ram_mwrite_q;
  logic [DATA_WIDTH-1:0]   ram_wdata_q;
  logic                    accept;

  assign accept = req_valid && req_ready_q;

`ifdef MEM_BYTE_STROBE_EN
  logic                    write_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   merged;

  byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_byte_merge (
    .old_data_i (ram_rdata),
    .new_data_i (wdata_q),
    .be_i       (be_q),
    .merged_o   (merged)
  );
`else
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      ram_raddr_q  <= '0;
      ram_waddr_q  <= '0;
      ram_mwrite_q <= 1'b0;
      ram_wdata_q  <= '0;
`ifdef MEM_BYTE_STROBE_EN
      write_q      <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
`ifdef MEM_BYTE_STROBE_EN
            write_q <= req_write;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            // Empty strobe is a no-op: stay in IDLE and keep accepting.
            if (req_write && (&req_be)) begin
              req_ready_q  <= 1'b0;
              ram_mwrite_q <= 1'b1;
              ram_waddr_q  <= req_addr;
              ram_wdata_q  <= req_wdata;
              state_q      <= WRITE;
            end else if (!req_write || (|req_be)) begin
              req_ready_q <= 1'b0;
              ram_raddr_q <= req_addr;
              state_q     <= RD_ADDR;
            end
`else
            req_ready_q <= 1'b0;
            if (req_write) begin
              ram_mwrite_q <= 1'b1;
              ram_waddr_q  <= req_addr;
              ram_wdata_q  <= req_wdata;
              state_q      <= WRITE;
            end else begin
              ram_raddr_q <= req_addr;
              state_q     <= RD_ADDR;
            end
`endif
          end
        end
        RD_ADDR: state_q <= RD_CAP;
        RD_CAP: begin
`ifdef MEM_BYTE_STROBE_EN
          if (write_q) begin
            ram_mwrite_q <= 1'b1;
            ram_waddr_q  <= ram_raddr_q;
            ram_wdata_q  <= merged;
            state_q      <= WRITE;
          end else begin
            resp_rdata_q <= ram_rdata;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
`else
          resp_rdata_q <= ram_rdata;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
`endif
        end
        WRITE: begin
          ram_mwrite_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          ram_mwrite_q <= 1'b0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_raddr  = ram_raddr_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_mwrite = ram_mwrite_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl paired with a behavioural data RAM.
// Build with MEM_BYTE_STROBE_EN defined to exercise the partial-strobe stores.
module tb_ram_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] ram_raddr;
  logic [AW-1:0] ram_waddr;
  logic          ram_mwrite;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          preload;
  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  int            n_cmp = 0;
  int            n_err = 0;
  int            pulses = 0;
  int            exp_pulses = 0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .ram_raddr  (ram_raddr),
    .ram_waddr  (ram_waddr),
    .ram_mwrite (ram_mwrite),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 16'(i * 263) ^ 16'hA000;
  endfunction

  // Data RAM: registered read, write on mwrite, contents loaded once at start.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= init_word(i);
    end else begin
      if (ram_mwrite) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
    end
  end

  always @(posedge clk) if (ram_mwrite) pulses <= pulses + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < BW; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic do_store(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [BW-1:0] be);
    logic [BW-1:0] eff_be;
    logic [DW-1:0] exp_word;
    int            k;
`ifdef MEM_BYTE_STROBE_EN
    eff_be = be;
    k = (be == '0) ? 0 : ((&be) ? 1 : 3);
`else
    eff_be = '1;
    k = 1;
`endif
    exp_word = merge_word(ref_mem[addr], data, eff_be);
    @(negedge clk);
    check_eq("st_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data; req_be = be;
    for (int c = 1; c <= k + 1; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      check_eq("st_mwrite", ram_mwrite, (c == k) ? 1 : 0);
      if (c == k) begin
        check_eq("st_waddr", ram_waddr, addr);
        check_eq("st_wdata", ram_wdata, exp_word);
      end
      if (c == k + 1) check_eq("st_done_ready", req_ready, 1);
    end
    if (k != 0) begin
      ref_mem[addr] = exp_word;
      exp_pulses++;
    end
    $display("store addr=%02h data=%04h be=%0b -> word %04h", addr, data, be, exp_word);
  endtask

  task automatic do_load(input logic [AW-1:0] addr, input int hold);
    @(negedge clk);
    check_eq("ld_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("ld_rv_t1", resp_valid, 0);
    check_eq("ld_busy", req_ready, 0);
    @(negedge clk);
    check_eq("ld_rv_t2", resp_valid, 0);
    @(negedge clk);
    check_eq("ld_rv_t3", resp_valid, 1);
    check_eq("ld_rdata", resp_rdata, ref_mem[addr]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("ld_hold_valid", resp_valid, 1);
      check_eq("ld_hold_rdata", resp_rdata, ref_mem[addr]);
      check_eq("ld_hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("ld_released", resp_valid, 0);
    check_eq("ld_idle_ready", req_ready, 1);
    $display("load  addr=%02h hold=%0d -> data %04h", addr, hold, ref_mem[addr]);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_word(i);
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_mwrite", ram_mwrite, 0);
    check_eq("rst_raddr", ram_raddr, 0);
    check_eq("rst_waddr", ram_waddr, 0);
    check_eq("rst_wdata", ram_wdata, 0);
    $display("reset released");
    reset = 1'b0;

    do_store(8'h10, 16'hBEEF, 2'b11);
    do_load(8'h10, 0);
    do_load(8'h05, 5);
    do_store(8'hFF, 16'h1234, 2'b11);
    do_load(8'hFF, 1);
    do_load(8'h00, 0);
`ifdef MEM_BYTE_STROBE_EN
    do_store(8'h20, 16'hAABB, 2'b11);
    do_store(8'h20, 16'h1122, 2'b01);
    do_load(8'h20, 0);
    do_store(8'h20, 16'h5566, 2'b00);
    do_load(8'h20, 0);
`endif

    // Reset while the load sits in RD_CAP: the response must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_ready", req_ready, 1);
    check_eq("rst_mid_valid", resp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_mid_no_resp", resp_valid, 0);
    end
    $display("reset mid-load: response dropped");
    do_load(8'h30, 0);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 2**AW - 1));
      if ($urandom_range(0, 1) == 1)
        do_store(a, DW'($urandom), BW'($urandom_range(0, 2**BW - 1)));
      else
        do_load(a, int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    check_eq("mwrite_pulses", pulses, exp_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
